// File: rtl/iterative_muldiv_if.sv
// Operand/writeback bundle between the register file and the iterative
// multiply/divide unit.
interface iterative_muldiv_if #(
  parameter int WIDTH = 64
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic [4:0]       Rd;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] BusW;
  logic [4:0]       RW;
  logic             RegWr;

  modport master (
    output Start, Op, BusA, BusB, Rd,
    input  Busy, Done, BusW, RW, RegWr
  );

  modport slave (
    input  Start, Op, BusA, BusB, Rd,
    output Busy, Done, BusW, RW, RegWr
  );
endinterface

// File: rtl/iterative_muldiv.sv
// One-bit-per-cycle MUL/UMULH/UDIV/SDIV unit: shift-add multiply and restoring
// divide sharing one hi/lo shift register pair, with a one-cycle writeback strobe.
module iterative_muldiv #(
  parameter int WIDTH = 64,
  parameter int ITER  = 64
) (
  input logic               Clk,
  input logic               Reset_n,
  iterative_muldiv_if.slave bus
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0]    CNT_LAST = CW'(ITER - 1);
  localparam logic [CW-1:0]    CNT_STEP = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       op_r;
  logic [4:0]       rd_r;
  logic             neg_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] busw_r;
  logic [4:0]       rw_r;
  logic             regwr_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;
  logic [WIDTH-1:0] result_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic as_signed);
    if (as_signed && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // One iteration step: lo holds multiplier/quotient, hi holds partial product/remainder.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + ({1'b0, b_r} & {(WIDTH+1){lo_r[0]}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s[WIDTH-1:0] - b_r;
    div_ge_s    = (div_shift_s >= {1'b0, b_r});
    hi_next_s   = hi_r;
    lo_next_s   = lo_r;
    if (op_r[1]) begin
      if (div_ge_s) begin
        hi_next_s = div_diff_s;
        lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_s = div_shift_s[WIDTH-1:0];
        lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next_s = mul_sum_s[WIDTH:1];
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Result selection on the final iteration; a zero divisor forces zero.
  always_comb begin
    result_s = ZERO;
    case (op_r)
      2'b00: result_s = lo_next_s;
      2'b01: result_s = hi_next_s;
      2'b10: begin
        if (b_r == ZERO) begin
          result_s = ZERO;
        end else begin
          result_s = lo_next_s;
        end
      end
      2'b11: begin
        if (b_r == ZERO) begin
          result_s = ZERO;
        end else if (neg_r) begin
          result_s = -lo_next_s;
        end else begin
          result_s = lo_next_s;
        end
      end
      default: result_s = ZERO;
    endcase
  end

  // Control FSM, iteration datapath and registered writeback outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= 2'b00;
      rd_r    <= 5'd0;
      neg_r   <= 1'b0;
      hi_r    <= ZERO;
      lo_r    <= ZERO;
      b_r     <= ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      busw_r  <= ZERO;
      rw_r    <= 5'd0;
      regwr_r <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      regwr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            op_r    <= bus.Op;
            rd_r    <= bus.Rd;
            // SDIV works on magnitudes; the sign is re-applied at the end.
            neg_r   <= (bus.Op == 2'b11) && (bus.BusA[WIDTH-1] ^ bus.BusB[WIDTH-1]);
            hi_r    <= ZERO;
            lo_r    <= magnitude(bus.BusA, bus.Op == 2'b11);
            b_r     <= magnitude(bus.BusB, bus.Op == 2'b11);
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          hi_r  <= hi_next_s;
          lo_r  <= lo_next_s;
          cnt_r <= cnt_r + CNT_STEP;
          if (cnt_r == CNT_LAST) begin
            done_r  <= 1'b1;
            busw_r  <= result_s;
            rw_r    <= rd_r;
            regwr_r <= (rd_r != 5'd31);
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy  = busy_r;
  assign bus.Done  = done_r;
  assign bus.BusW  = busw_r;
  assign bus.RW    = rw_r;
  assign bus.RegWr = regwr_r;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Self-checking bench for iterative_muldiv: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_iterative_muldiv;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  iterative_muldiv_if #(.WIDTH(64)) bus ();

  iterative_muldiv #(.WIDTH(64), .ITER(64)) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return MIN64;
      2: return ALL1;
      3: return 64'($urandom_range(1, 20));
      4: return 64'd0 - 64'($urandom_range(1, 20));
      default: return rand64();
    endcase
  endfunction

  // Reference: arithmetic straight from the instruction definitions.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (op)
      2'b00: return p[63:0];
      2'b01: return p[127:64];
      2'b10: return (b == 64'd0) ? 64'd0 : a / b;
      default: begin
        if (b == 64'd0) return 64'd0;
        if (a == MIN64 && b == ALL1) return MIN64;
        return $signed(a) / $signed(b);
      end
    endcase
  endfunction

  // Issues one op from a negedge in IDLE and observes it until one cycle after Done.
  task automatic issue_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int pulse_run, input bit pulse_done,
                          output int lat, output logic [63:0] w, output logic [4:0] rw,
                          output logic wr, output int busy_cnt, output int wr_cnt,
                          output logic after_busy, output logic after_done,
                          output logic [63:0] after_w);
    bus.Start = 1'b1; bus.Op = op; bus.BusA = a; bus.BusB = b; bus.Rd = rd;
    lat = -1; w = 64'd0; rw = 5'd0; wr = 1'b0; busy_cnt = 0; wr_cnt = 0;
    @(posedge clk);
    #1;
    bus.Start = 1'b0; bus.BusA = rand64(); bus.BusB = rand64();
    bus.Op = 2'($urandom_range(0, 3)); bus.Rd = 5'($urandom_range(0, 31));
    for (int j = 1; j <= 200 && lat < 0; j++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.RegWr === 1'b1) wr_cnt++;
      if (bus.Done === 1'b1) begin
        lat = j - 1; w = bus.BusW; rw = bus.RW; wr = bus.RegWr;
        if (pulse_done) bus.Start = 1'b1;
      end else if (j == pulse_run) begin
        bus.Start = 1'b1;
      end
    end
    @(negedge clk);
    bus.Start = 1'b0;
    after_busy = bus.Busy; after_done = bus.Done; after_w = bus.BusW;
    if (bus.RegWr === 1'b1) wr_cnt++;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.Op = 2'b00; bus.BusA = 64'd0; bus.BusB = 64'd0; bus.Rd = 5'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.Busy, bus.Done, bus.RegWr, bus.RW, bus.BusW} !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b regwr=%b rw=%0d busw=%h, expected all zero",
               bus.Busy, bus.Done, bus.RegWr, bus.RW, bus.BusW);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_start: busy=%b expected 0", bus.Busy);
    end
  endtask

  task automatic test_mul_basic();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b00, 64'd7, 64'd6, 5'd5, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (lat !== 64) begin tests_failed++; $display("FAIL mul_latency: got %0d expected 64", lat); end
    tests_run++; if (w !== 64'd42) begin tests_failed++; $display("FAIL mul_result: got %0d expected 42", w); end
    tests_run++; if (rw !== 5'd5 || wr !== 1'b1) begin tests_failed++; $display("FAIL mul_writeback: rw=%0d regwr=%b expected 5/1", rw, wr); end
    tests_run++; if (bc !== 65) begin tests_failed++; $display("FAIL mul_busy_cycles: got %0d expected 65", bc); end
    tests_run++; if (wc !== 1) begin tests_failed++; $display("FAIL mul_single_write: got %0d expected 1", wc); end
    tests_run++; if (ab !== 1'b0 || ad !== 1'b0) begin tests_failed++; $display("FAIL mul_after_done: busy=%b done=%b expected 0/0", ab, ad); end
    tests_run++; if (aw !== 64'd42) begin tests_failed++; $display("FAIL mul_busw_hold: got %0d expected 42", aw); end
  endtask

  task automatic test_mul_wide();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b01, ALL1, ALL1, 5'd1, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL umulh_ones: got %h expected fffffffffffffffe", w); end
    issue_op(2'b00, ALL1, ALL1, 5'd2, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'd1) begin tests_failed++; $display("FAIL mul_ones: got %h expected 1", w); end
  endtask

  task automatic test_divide();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b10, 64'd100, 64'd7, 5'd3, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'd14) begin tests_failed++; $display("FAIL udiv_100_7: got %0d expected 14", w); end
    issue_op(2'b11, 64'd0 - 64'd100, 64'd7, 5'd4, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'hFFFF_FFFF_FFFF_FFF2) begin tests_failed++; $display("FAIL sdiv_neg100_7: got %h expected fffffffffffffff2", w); end
    issue_op(2'b11, MIN64, ALL1, 5'd6, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== MIN64) begin tests_failed++; $display("FAIL sdiv_overflow: got %h expected 8000000000000000", w); end
  endtask

  task automatic test_div_by_zero();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b10, 64'd5, 64'd0, 5'd8, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'd0 || lat !== 64) begin tests_failed++; $display("FAIL udiv_by_zero: got %h lat %0d expected 0 lat 64", w, lat); end
    issue_op(2'b11, 64'd0 - 64'd5, 64'd0, 5'd9, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'd0 || lat !== 64) begin tests_failed++; $display("FAIL sdiv_by_zero: got %h lat %0d expected 0 lat 64", w, lat); end
  endtask

  task automatic test_rd31();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b00, 64'd3, 64'd3, 5'd31, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (lat !== 64 || w !== 64'd9) begin tests_failed++; $display("FAIL rd31_done: lat %0d busw %0d expected 64/9", lat, w); end
    tests_run++; if (wc !== 0) begin tests_failed++; $display("FAIL rd31_no_write: regwr cycles %0d expected 0", wc); end
  endtask

  task automatic test_start_ignored();
    int lat, bc, wc; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b00, 64'd11, 64'd13, 5'd10, 10, 1'b1, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (lat !== 64 || w !== 64'd143) begin tests_failed++; $display("FAIL start_in_run: lat %0d busw %0d expected 64/143", lat, w); end
    tests_run++; if (ab !== 1'b0 || wc !== 1) begin tests_failed++; $display("FAIL start_in_done: busy after=%b writes=%0d expected 0/1", ab, wc); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, wc, strobes; logic [63:0] w, aw; logic [4:0] rw; logic wr, ab, ad;
    issue_op(2'b00, 64'd5, 64'd5, 5'd3, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.BusA = 64'd9; bus.BusB = 64'd9; bus.Rd = 5'd12;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.Busy, bus.Done, bus.RegWr, bus.RW, bus.BusW} !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: busy=%b done=%b regwr=%b rw=%0d busw=%h expected all zero",
               bus.Busy, bus.Done, bus.RegWr, bus.RW, bus.BusW);
    end
    reset_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.RegWr !== 1'b0) strobes++;
    end
    tests_run++; if (strobes !== 0) begin tests_failed++; $display("FAIL reset_discard: strobe cycles %0d expected 0", strobes); end
    issue_op(2'b00, 64'd2, 64'd3, 5'd7, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
    tests_run++; if (w !== 64'd6 || lat !== 64) begin tests_failed++; $display("FAIL after_reset_mul: busw %0d lat %0d expected 6/64", w, lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, wc; logic [63:0] w, aw, a, b; logic [4:0] rw; logic wr, ab, ad;
    for (int i = 0; i < 4; i++) begin
      a = rand64(); b = 64'($urandom_range(1, 1000));
      issue_op(2'(i), a, b, 5'(i + 20), -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
      tests_run++;
      if (bc !== 65 || w !== model(2'(i), a, b)) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d: busy %0d busw %h expected 65/%h", i, bc, w, model(2'(i), a, b));
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, wc; logic [63:0] w, aw, a, b, exp_w; logic [4:0] rw, rd; logic wr, ab, ad;
    logic [1:0] op;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand();
      rd = 5'($urandom_range(0, 31));
      exp_w = model(op, a, b);
      issue_op(op, a, b, rd, -1, 1'b0, lat, w, rw, wr, bc, wc, ab, ad, aw);
      tests_run++;
      if (lat !== 64 || w !== exp_w || rw !== rd || wr !== (rd != 5'd31) || ab !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: busw %h rw %0d regwr %b lat %0d, expected %h rw %0d regwr %b lat 64",
                 i, op, a, b, w, rw, wr, lat, exp_w, rd, (rd != 5'd31));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_wide();
    test_divide();
    test_div_by_zero();
    test_rd31();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
